// File: rtl/mem_wb_ctrl.sv
// MEM->WB handshake sequencer: issues data-memory requests, stalls upstream stages while an
// access is outstanding, and decides whether RegMW captures the instruction or a bubble.
module mem_wb_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    input  logic        mem_load_i,
    input  logic        mem_store_i,
    input  logic        flush_i,
    input  logic        dmem_req_ready_i,
    input  logic        dmem_rsp_valid_i,
    output logic        dmem_req_valid_o,
    output logic        dmem_req_we_o,
    output logic        stall_o,
    output logic        mw_valid_o,
    output logic        timeout_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic access;
    logic expired;
    logic req_valid;
    logic stall;
    logic mw_valid;

    assign access  = mem_load_i | mem_store_i;
    assign expired = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        stall     = 1'b0;
        mw_valid  = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush_i && mem_valid_i) begin
                    if (!access) begin
                        mw_valid = 1'b1;
                    end else begin
                        req_valid = 1'b1;
                        if (!dmem_req_ready_i) begin
                            stall   = 1'b1;
                            state_d = REQ;
                        end else if (mem_store_i) begin
                            mw_valid = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT_RSP;
                        end
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (dmem_req_ready_i) begin
                    // Acceptance wins over a timeout landing in the same cycle.
                    req_valid = 1'b1;
                    if (mem_store_i) begin
                        mw_valid = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT_RSP;
                    end
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    req_valid = 1'b1;
                    stall     = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (flush_i) begin
                    state_d = dmem_rsp_valid_i ? IDLE : DRAIN;
                end else if (dmem_rsp_valid_i) begin
                    mw_valid = 1'b1;
                    state_d  = IDLE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            DRAIN: begin
                // The killed load's response is still owed; swallow it before new requests.
                if (flush_i) begin
                    if (dmem_rsp_valid_i) begin
                        state_d = IDLE;
                    end
                end else if (expired && !dmem_rsp_valid_i) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall    = mem_valid_i & access;
                    mw_valid = mem_valid_i & ~access;
                    if (dmem_rsp_valid_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_d == IDLE || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem_req_valid_o = req_valid;
    assign dmem_req_we_o    = req_valid & mem_store_i;
    assign stall_o          = stall;
    assign mw_valid_o       = mw_valid;
    assign timeout_o        = timeout_q;
    assign busy_o           = (state_q != IDLE);
    assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed bench for mem_wb_ctrl: ALU pass-through, load/store handshakes, flush/drain,
// timeout abort and asynchronous reset, with hand-computed expectations.
module tb_mem_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_valid_i, mem_load_i, mem_store_i, flush_i;
    logic        dmem_req_ready_i, dmem_rsp_valid_i;
    logic        dmem_req_valid_o, dmem_req_we_o, stall_o, mw_valid_o, timeout_o, busy_o;
    logic [31:0] stall_cnt_o;

    int tests;
    int fails;

    mem_wb_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_valid_i      (mem_valid_i),
        .mem_load_i       (mem_load_i),
        .mem_store_i      (mem_store_i),
        .flush_i          (flush_i),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_we_o    (dmem_req_we_o),
        .stall_o          (stall_o),
        .mw_valid_o       (mw_valid_o),
        .timeout_o        (timeout_o),
        .busy_o           (busy_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {req_valid, we, stall, mw_valid}
    task automatic chk_outs(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, dmem_req_valid_o, dmem_req_we_o, stall_o, mw_valid_o}, {28'd0, exp});
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic fl,
                         input logic rdy, input logic rsp);
        mem_valid_i      = v;
        mem_load_i       = ld;
        mem_store_i      = st;
        flush_i          = fl;
        dmem_req_ready_i = rdy;
        dmem_rsp_valid_i = rsp;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk_outs("reset_outs", 4'b0000);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_timeout", {31'd0, timeout_o}, 32'd0);
        check("reset_stall_cnt", stall_cnt_o, 32'd0);
        rst_n = 1'b1;
        adv();

        // ALU stream: zero-latency pass-through
        $display("[TB] ALU op stream x4");
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk_outs($sformatf("alu_%0d", i), 4'b0001);
            adv();
        end
        check("alu_stall_cnt", stall_cnt_o, 32'd0);

        // Load accepted at once, response on third cycle
        $display("[TB] load, rsp after 3 cycles");
        drive(1, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk_outs("ld_issue", 4'b1010);
        adv();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            @(negedge clk);
            chk_outs($sformatf("ld_wait_%0d", i), 4'b0010);
            check("ld_busy", {31'd0, busy_o}, 32'd1);
            adv();
        end
        drive(1, 1, 0, 0, 0, 1);
        @(negedge clk);
        chk_outs("ld_rsp", 4'b0001);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ld_idle_busy", {31'd0, busy_o}, 32'd0);
        check("ld_stall_cnt", stall_cnt_o, 32'd3);
        adv();

        // Store with ready low for two cycles
        $display("[TB] store, ready low 2 cycles");
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 0, 0, 0);
            @(negedge clk);
            chk_outs($sformatf("st_hold_%0d", i), 4'b1110);
            adv();
        end
        drive(1, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk_outs("st_accept", 4'b1101);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("st_idle_busy", {31'd0, busy_o}, 32'd0);
        check("st_stall_cnt", stall_cnt_o, 32'd5);
        adv();

        // Load accepted, flushed while waiting, response drained
        $display("[TB] load, flush, drain");
        drive(1, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk_outs("fl_issue", 4'b1010);
        adv();
        drive(1, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk_outs("fl_flush", 4'b0000);
        adv();
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fl_drain_busy", {31'd0, busy_o}, 32'd1);
        chk_outs("fl_drain_alu", 4'b0001);
        adv();
        drive(1, 1, 0, 0, 1, 1);
        @(negedge clk);
        chk_outs("fl_drain_rsp", 4'b0010);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fl_idle_busy", {31'd0, busy_o}, 32'd0);
        check("fl_stall_cnt", stall_cnt_o, 32'd7);
        adv();

        // Load never answered: abort after 4 stalled WAIT_RSP cycles
        $display("[TB] load timeout");
        drive(1, 1, 0, 0, 1, 0);
        @(negedge clk);
        chk_outs("to_issue", 4'b1010);
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            @(negedge clk);
            chk_outs($sformatf("to_wait_%0d", i), 4'b0010);
            check($sformatf("to_nopulse_%0d", i), {31'd0, timeout_o}, 32'd0);
            adv();
        end
        @(negedge clk);
        chk_outs("to_abort", 4'b0000);
        check("to_abort_pulse", {31'd0, timeout_o}, 32'd0);
        adv();
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("to_pulse", {31'd0, timeout_o}, 32'd1);
        check("to_idle_busy", {31'd0, busy_o}, 32'd0);
        chk_outs("to_late_rsp", 4'b0000);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("to_pulse_end", {31'd0, timeout_o}, 32'd0);
        check("to_stall_cnt", stall_cnt_o, 32'd12);
        adv();

        // Flush of an access in IDLE: no request, no stall
        $display("[TB] flush in IDLE");
        drive(1, 1, 0, 1, 1, 0);
        @(negedge clk);
        chk_outs("fi_outs", 4'b0000);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fi_busy", {31'd0, busy_o}, 32'd0);
        adv();

        // Asynchronous reset while waiting for a response
        $display("[TB] async reset mid-WAIT_RSP");
        drive(1, 1, 0, 0, 1, 0);
        adv();
        drive(1, 1, 0, 0, 0, 0);
        #1;
        check("ar_busy_before", {31'd0, busy_o}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy_o}, 32'd0);
        check("ar_stall", {31'd0, stall_o}, 32'd0);
        check("ar_stall_cnt", stall_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
